// File: rtl/simon_sequencer.sv
// Simon game core: grows a random symbol sequence one entry per round,
// plays it back on four LEDs, then checks the player's presses against it.
module simon_sequencer #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 6000000,
    parameter int GAP_CYCLES     = 1200000,
    parameter int TIMEOUT_CYCLES = 60000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] rnd,
    input  logic [3:0] btn,
    output logic [3:0] led,
    output logic [5:0] level,
    output logic       busy,
    output logic       win,
    output logic       lose
);
    localparam int IW = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, PAUSE, WIN, LOSE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [5:0]    level_q, level_d;
    logic [3:0]    led_q, led_d;
    logic          busy_q, busy_d, win_q, win_d, lose_q, lose_d;
    logic [1:0]    mem_q [MAX_LEN];
    logic          mem_we;
    logic          timer_clr;
    logic          last;
    logic [3:0]    exp_btn;
    logic [1:0]    show_sym;
    logic          unused_rnd;

    // Only the low two counter bits form a symbol.
    assign unused_rnd = rnd[2];

    assign last    = (6'(idx_q) == level_q - 6'd1);
    assign exp_btn = 4'b0001 << mem_q[idx_q];

    // Next-state, sequence index, level and timer control.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        level_d   = level_q;
        mem_we    = 1'b0;
        timer_clr = 1'b0;
        case (state_q)
            IDLE, WIN, LOSE: begin
                if (start) begin
                    state_d = ADD;
                    level_d = 6'd0;
                end
            end
            ADD: begin
                mem_we  = 1'b1;
                level_d = level_q + 6'd1;
                idx_d   = '0;
                state_d = SHOW_ON;
            end
            SHOW_ON: begin
                if (timer_q == 32'(SHOW_CYCLES - 1)) state_d = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (timer_q == 32'(GAP_CYCLES - 1)) begin
                    if (last) begin
                        state_d = WAIT_IN;
                        idx_d   = '0;
                    end else begin
                        state_d = SHOW_ON;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            WAIT_IN: begin
                // A correct press outranks a timeout landing on the same cycle.
                if (btn == exp_btn) begin
                    if (last) begin
                        state_d = (level_q == 6'(MAX_LEN)) ? WIN : PAUSE;
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        timer_clr = 1'b1;
                    end
                end else if (btn != 4'b0000) begin
                    state_d = LOSE;
                end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = LOSE;
                end
            end
            PAUSE: begin
                if (timer_q == 32'(GAP_CYCLES - 1)) state_d = ADD;
            end
            default: state_d = IDLE;
        endcase
        timer_d = (state_d != state_q || timer_clr) ? 32'd0 : timer_q + 32'd1;
    end

    // Registered outputs decoded from the upcoming state; the symbol being
    // written in ADD is forwarded so the first playback LED is correct.
    always_comb begin
        show_sym = mem_q[idx_d];
        if (state_q == ADD && 6'(idx_d) == level_q) show_sym = rnd[1:0];
        led_d = 4'b0000;
        case (state_d)
            SHOW_ON: led_d = 4'b0001 << show_sym;
            WIN:     led_d = 4'b0101;
            LOSE:    led_d = 4'b1111;
            default: led_d = 4'b0000;
        endcase
        busy_d = (state_d == ADD) || (state_d == SHOW_ON) ||
                 (state_d == SHOW_OFF) || (state_d == PAUSE);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= 32'd0;
            idx_q   <= '0;
            level_q <= 6'd0;
            led_q   <= 4'b0000;
            busy_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // Sequence memory survives reset; only ADD appends to it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[level_q[IW-1:0]] <= rnd[1:0];
    end

    assign led   = led_q;
    assign level = level_q;
    assign busy  = busy_q;
    assign win   = win_q;
    assign lose  = lose_q;
endmodule

// File: doc/simon_sequencer.md
Name: simon_sequencer

Overview:
- Game core for the Python_says demo. Sits directly downstream of the prescaled free-running 3-bit counter and consumes its `data` output as a random source.
- Each round it appends one symbol (counter bits [1:0]) to a stored sequence. It then plays the whole sequence on 4 LEDs and checks the player's button presses against it.
- It reports level, win and lose to the top level.

Parameters:
- MAX_LEN, 16: maximum sequence length; reaching and completing it is a win. Range 2..32.
- SHOW_CYCLES, 6000000: clk cycles each symbol LED is lit during playback.
- GAP_CYCLES, 1200000: clk cycles of all-LEDs-off after each symbol, and before a new round.
- TIMEOUT_CYCLES, 60000000: clk cycles allowed between button presses in WAIT_IN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: single-cycle strobe that starts or restarts a game.
- rnd, input, 3: counter value; only rnd[1:0] is used.
- btn, input, 4: debounced single-cycle press strobes, one bit per LED/button.
- led, output, 4: one-hot symbol display or status pattern.
- level, output, 6: current sequence length (0..MAX_LEN).
- busy, output, 1: high in ADD, SHOW_ON, SHOW_OFF and PAUSE.
- win, output, 1: high in WIN.
- lose, output, 1: high in LOSE.

Behaviour:
- Single clock domain.
- rst is synchronous and active-high. On the next clk edge with rst=1, from any state:
  - state becomes IDLE
  - led=0, level=0, win=0, lose=0, busy=0
  - timer and index clear
- The sequence memory is not cleared by reset; it holds MAX_LEN entries of 2 bits each.
- All outputs are registered. led is the one-hot decode of the 2-bit symbol: 0 gives 0001, 3 gives 1000.
- A timer counts clk cycles in each timed state and clears on every state entry. A timed state is left on the cycle its timer reaches its parameter minus 1, so it lasts exactly that parameter in cycles.
- IDLE: led=0. start moves to ADD with level cleared to 0.
- ADD, one cycle:
  - mem[level] <= rnd[1:0]; level <= level+1; idx <= 0.
  - Next state is SHOW_ON.
- SHOW_ON: led=onehot(mem[idx]) for SHOW_CYCLES cycles, then SHOW_OFF.
- SHOW_OFF: led=0 for GAP_CYCLES cycles. At the end:
  - if idx==level-1, go to WAIT_IN with idx=0;
  - else idx++ and go to SHOW_ON.
- WAIT_IN: led=0, timer runs.
  - btn==0: no effect.
  - btn is exactly one-hot and equals onehot(mem[idx]):
    - idx==level-1 and level==MAX_LEN: go to WIN.
    - idx==level-1 and level<MAX_LEN: go to PAUSE.
    - otherwise: idx++ and the timer clears.
  - btn is any other nonzero value (wrong bit or multiple bits): go to LOSE.
  - Timer reaches TIMEOUT_CYCLES-1 with no press: go to LOSE. A correct press on that same cycle takes priority.
- PAUSE: led=0 for GAP_CYCLES cycles, then ADD.
- WIN: led=0101, win=1, level held. start gives ADD with level=0.
- LOSE: led=1111, lose=1, level held (score shown). start gives ADD with level=0.
- start in ADD, SHOW_ON, SHOW_OFF, WAIT_IN or PAUSE is ignored.
- btn outside WAIT_IN is ignored.
- rst asserted together with start: rst wins.
- rnd is sampled only in ADD. Its value is unconstrained; any 3-bit value is legal.

Test Plan:
- All scenarios use MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20.
- Reset: hold rst 2 cycles mid-SHOW_ON -> led=0000, level=0, win=lose=busy=0 on the first edge; stays in IDLE with no start.
- Round 1: rnd=3'b110 at start, pulse start -> level=1 after one cycle; led=0100 for exactly 4 cycles, then 0000 for 2; busy drops; btn=0100 -> PAUSE (busy=1) -> ADD samples new rnd -> level=2.
- Full win: feed rnd low bits 2,0,3 across rounds and answer every playback correctly -> after the third correct press of round 3, win=1 and led=0101; start -> level=1, win=0.
- Wrong press: round 2 sequence 2,0; press 0100 then 0010 -> lose=1, led=1111, level=2 held; btn pulses in LOSE change nothing.
- Timeout: enter WAIT_IN and give no input -> lose=1 exactly 20 cycles after entry. Variant: a correct press on cycle 19 -> no lose, timer restarts.
- Illegal input and ignored start: btn=0011 in WAIT_IN -> LOSE. start pulsed during SHOW_ON -> playback continues unchanged and level is unchanged.
